// File: rtl/dcache_if.sv
// dcache_if: CPU data-port and backing-memory signals of the data cache responder
interface dcache_if #(parameter int ADDR_W = 8, parameter int DATA_W = 16);
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_dataout;
  logic [DATA_W-1:0] d_datain;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  d_req, d_we, d_addr, d_dataout, mem_ack, mem_rdata,
    output d_datain, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output d_req, d_we, d_addr, d_dataout, mem_ack, mem_rdata,
    input  d_datain, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-allocate data cache with req/ack memory side
// Optional hit/miss counters when DCACHE_STATS_EN is defined.
module dcache_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 4
) (
  input logic clock,
  input logic reset,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_W-1:0] data [LINES];
  logic [INDEX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag;
  logic hit, go, fill;
  assign idx  = bus.d_addr[INDEX_W-1:0];
  assign tag  = bus.d_addr[ADDR_W-1:INDEX_W];
  assign fidx = bus.mem_addr[INDEX_W-1:0];
  assign hit  = valid[idx] && tags[idx] == tag;
  assign go   = state == IDLE && bus.d_req && (bus.d_we || !hit);
  assign fill = state == FILL && bus.mem_ack;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = go ? (bus.d_we ? WRITE : FILL) : IDLE;
    else if (bus.mem_ack) state_n = IDLE;
  end
  // WRITE releases the stall in the ack cycle; FILL holds it until the line is written
  always_comb begin
    bus.stall    = state == IDLE ? go : (state == FILL ? 1'b1 : !bus.mem_ack);
    bus.d_datain = (state == IDLE && bus.d_req && !bus.d_we && hit) ? data[idx] : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (go) begin
      bus.mem_req  <= 1'b1;
      bus.mem_we   <= bus.d_we;
      bus.mem_addr <= bus.d_addr;
      if (bus.d_we) bus.mem_wdata <= bus.d_dataout;
    end else if (state != IDLE && bus.mem_ack) begin
      bus.mem_req <= 1'b0;
      bus.mem_we  <= 1'b0;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) valid <= '0;
    else if (fill) valid[fidx] <= 1'b1;
  always_ff @(posedge clock)
    if (fill) begin
      tags[fidx] <= bus.mem_addr[ADDR_W-1:INDEX_W];
      data[fidx] <= bus.mem_rdata;
    end else if (go && bus.d_we && hit) data[idx] <= bus.d_dataout;
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && bus.d_req) begin
      if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed checks of hit/miss, write-through, stall timing and reset abort
module tb_dcache_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int st, rq;
  logic [7:0] ma;
  logic mw;
  logic [15:0] md, rd;
  bit sb;
  dcache_if #(.ADDR_W(8), .DATA_W(16)) bus();
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  dcache_responder #(.ADDR_W(8), .DATA_W(16), .INDEX_W(4)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .hit_count(hit_count), .miss_count(miss_count));
`else
  dcache_responder #(.ADDR_W(8), .DATA_W(16), .INDEX_W(4)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
`endif
  always #5 clock = ~clock;

  // Drives one held request and plays backing memory, acking on the ack_n-th mem_req cycle.
  task automatic access(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                        input int ack_n, input logic [15:0] rdata,
                        output int stalls, output int reqs, output logic [7:0] maddr,
                        output logic mwe, output logic [15:0] mwd, output logic [15:0] rdo,
                        output bit stable);
    bit done = 0;
    int cyc = 0;
    stalls = 0; reqs = 0; stable = 1; maddr = '0; mwe = 0; mwd = '0; rdo = '0;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_dataout = wd;
    while (!done && cyc < 40) begin
      if (bus.mem_req) begin
        if (reqs > 0 && (bus.mem_addr !== maddr || bus.mem_we !== mwe || bus.mem_wdata !== mwd)) stable = 0;
        maddr = bus.mem_addr; mwe = bus.mem_we; mwd = bus.mem_wdata; reqs++;
        if (reqs == ack_n) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdata; end
      end
      @(negedge clock);
      if (bus.stall) stalls++; else begin done = 1; rdo = bus.d_datain; end
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
      cyc++;
    end
    bus.d_req = 1'b0;
    if (!done) stalls = -1;
  endtask

  task automatic test_reset();
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_dataout = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_tests++; if (bus.d_datain !== 16'h0) begin n_fail++; $display("FAIL reset_datain: got %h want 0000", bus.d_datain); end
    n_tests++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_req_we: got %b want 00", {bus.mem_req, bus.mem_we}); end
    n_tests++; if ({bus.mem_addr, bus.mem_wdata} !== 24'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h want 000000", {bus.mem_addr, bus.mem_wdata}); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_cold_miss();
    access(1'b0, 8'h00, 16'h0, 2, 16'h13ab, st, rq, ma, mw, md, rd, sb);
    n_tests++; if (st !== 3) begin n_fail++; $display("FAIL cold_stall_cycles: got %0d want 3", st); end
    n_tests++; if (rq !== 2) begin n_fail++; $display("FAIL cold_req_cycles: got %0d want 2", rq); end
    n_tests++; if ({ma, mw} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL cold_req_addr_we: got %h/%b want 00/0", ma, mw); end
    n_tests++; if (!sb) begin n_fail++; $display("FAIL cold_req_stable: got unstable want stable"); end
    n_tests++; if (rd !== 16'h13ab) begin n_fail++; $display("FAIL cold_datain: got %h want 13ab", rd); end
    @(negedge clock);
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_drop: got %b want 0", bus.mem_req); end
    @(posedge clock); #1;
  endtask

  task automatic test_load_hit();
    access(1'b0, 8'h00, 16'h0, 1, 16'hdead, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({st, rq} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL hit_stall_req: got %0d/%0d want 0/0", st, rq); end
    n_tests++; if (rd !== 16'h13ab) begin n_fail++; $display("FAIL hit_datain: got %h want 13ab", rd); end
  endtask

  task automatic test_conflict_miss();
    access(1'b0, 8'h10, 16'h0, 1, 16'h14cc, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({rq, ma} !== {32'd1, 8'h10}) begin n_fail++; $display("FAIL conflict_req: got %0d/%h want 1/10", rq, ma); end
    n_tests++; if (rd !== 16'h14cc) begin n_fail++; $display("FAIL conflict_datain: got %h want 14cc", rd); end
    access(1'b0, 8'h00, 16'h0, 1, 16'h13ab, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({rq, ma, st} !== {32'd1, 8'h00, 32'd2}) begin n_fail++; $display("FAIL conflict_remiss: got req %0d addr %h stall %0d want 1/00/2", rq, ma, st); end
    n_tests++; if (rd !== 16'h13ab) begin n_fail++; $display("FAIL conflict_refill: got %h want 13ab", rd); end
  endtask

  task automatic test_store_hit();
    access(1'b0, 8'h01, 16'h0, 1, 16'h00cc, st, rq, ma, mw, md, rd, sb);
    n_tests++; if (rd !== 16'h00cc) begin n_fail++; $display("FAIL store_prefill: got %h want 00cc", rd); end
    access(1'b1, 8'h01, 16'h1088, 2, 16'h0, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({ma, mw, md} !== {8'h01, 1'b1, 16'h1088}) begin n_fail++; $display("FAIL store_hit_req: got %h/%b/%h want 01/1/1088", ma, mw, md); end
    n_tests++; if ({st, rq} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL store_hit_timing: got stall %0d req %0d want 2/2", st, rq); end
    n_tests++; if (!sb) begin n_fail++; $display("FAIL store_hit_stable: got unstable want stable"); end
    @(negedge clock);
    n_tests++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin n_fail++; $display("FAIL store_hit_drop: got %b want 00", {bus.mem_req, bus.mem_we}); end
    @(posedge clock); #1;
    access(1'b0, 8'h01, 16'h0, 1, 16'hdead, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({rq, rd} !== {32'd0, 16'h1088}) begin n_fail++; $display("FAIL store_hit_reload: got req %0d data %h want 0/1088", rq, rd); end
  endtask

  task automatic test_store_miss();
    access(1'b1, 8'h22, 16'h4220, 1, 16'h0, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({ma, mw, md, st} !== {8'h22, 1'b1, 16'h4220, 32'd1}) begin n_fail++; $display("FAIL store_miss_req: got %h/%b/%h stall %0d want 22/1/4220/1", ma, mw, md, st); end
    access(1'b0, 8'h22, 16'h0, 1, 16'h5555, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({rq, ma, mw} !== {32'd1, 8'h22, 1'b0}) begin n_fail++; $display("FAIL store_miss_noalloc: got req %0d addr %h we %b want 1/22/0", rq, ma, mw); end
    n_tests++; if (rd !== 16'h5555) begin n_fail++; $display("FAIL store_miss_fill: got %h want 5555", rd); end
  endtask

  task automatic test_idle_ack();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hffff;
    @(negedge clock);
    n_tests++; if ({bus.mem_req, bus.stall} !== 2'b00) begin n_fail++; $display("FAIL idle_ack_quiet: got %b want 00", {bus.mem_req, bus.stall}); end
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    access(1'b0, 8'h00, 16'h0, 1, 16'hdead, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({rq, rd} !== {32'd0, 16'h13ab}) begin n_fail++; $display("FAIL idle_ack_ignored: got req %0d data %h want 0/13ab", rq, rd); end
  endtask

  task automatic test_reset_mid_fill();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h33;
    @(posedge clock); #1;
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midfill_req: got %b want 1", bus.mem_req); end
    @(negedge clock);
    reset = 1'b1; #1;
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL midfill_async_drop: got %b want 0", bus.mem_req); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hbeef;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0; bus.d_req = 1'b0;
    reset = 1'b0;
`ifdef DCACHE_STATS_EN
    n_tests++; if ({hit_count, miss_count} !== 32'h0) begin n_fail++; $display("FAIL stats_reset: got %h/%h want 0000/0000", hit_count, miss_count); end
`endif
    access(1'b0, 8'h33, 16'h0, 1, 16'h7777, st, rq, ma, mw, md, rd, sb);
    n_tests++; if ({rq, ma, st} !== {32'd1, 8'h33, 32'd2}) begin n_fail++; $display("FAIL midfill_remiss: got req %0d addr %h stall %0d want 1/33/2", rq, ma, st); end
    n_tests++; if (rd !== 16'h7777) begin n_fail++; $display("FAIL midfill_refill: got %h want 7777", rd); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    n_tests++; if ({hit_count, miss_count} !== {16'd8, 16'd6}) begin n_fail++; $display("FAIL stats_counts: got %0d/%0d want 8/6", hit_count, miss_count); end
  endtask

  task automatic test_stats_saturate();
    @(negedge clock);
    force dut.hit_count = 16'hFFFE;
    force dut.miss_count = 16'hFFFE;
    @(posedge clock); #1;
    release dut.hit_count;
    release dut.miss_count;
    repeat (3) access(1'b0, 8'h33, 16'h0, 1, 16'h0, st, rq, ma, mw, md, rd, sb);
    repeat (2) access(1'b1, 8'h44, 16'h0044, 1, 16'h0, st, rq, ma, mw, md, rd, sb);
    @(negedge clock);
    n_tests++; if ({hit_count, miss_count} !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_saturate: got %h/%h want ffff/ffff", hit_count, miss_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_load_hit();
    test_conflict_miss();
    test_store_hit();
    test_store_miss();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_idle_ack();
    test_reset_mid_fill();
`ifdef DCACHE_STATS_EN
    test_stats_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
